// File: rtl/tohost_mailbox.sv
// tohost_mailbox: HTIF-style tohost/fromhost mailbox on a single-beat MMIO request port.
// Optional feature macro: TOHOST_TIMEOUT_EN (ack timeout with sticky error flag).
module tohost_mailbox #(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter logic [ADDR_W-1:0] FROMHOST_ADDR  = 32'h8000_1040,
  parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [63:0]       i_req_wdata,
  input  logic [7:0]        i_req_wstrb,
  output logic              o_resp_valid,
  output logic [63:0]       o_resp_rdata,
  output logic [63:0]       o_tohost,
  input  logic              i_tohost_ack,
  input  logic              i_fromhost_valid,
  input  logic [63:0]       i_fromhost_data,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]  r_state, w_state_next;
  logic [63:0] r_tohost, w_tohost_next;
  logic [63:0] r_fromhost, w_fromhost_next;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_timeout_err, w_timeout_err_next;
  logic        w_hit_tohost, w_hit_fromhost;
  logic        w_accept, w_store, w_load;
  logic [63:0] w_merge_tohost, w_merge_fromhost, w_load_data;
  logic        w_timeout_fire;

  function automatic logic [63:0] f_merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                          input logic [7:0] strb);
    logic [63:0] res;
    res = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode ignores the byte offset within the 8-byte word.
  assign w_hit_tohost   = (i_req_addr[ADDR_W-1:3] == TOHOST_ADDR[ADDR_W-1:3]);
  assign w_hit_fromhost = (i_req_addr[ADDR_W-1:3] == FROMHOST_ADDR[ADDR_W-1:3]);

  // Only tohost traffic stalls while the bench has not yet acknowledged.
  assign o_req_ready = !((r_state == ST_PENDING) && w_hit_tohost);

  assign w_accept = i_req_valid && o_req_ready;
  assign w_store  = w_accept && i_req_write;
  assign w_load   = w_accept && !i_req_write;

  assign w_merge_tohost   = f_merge(r_tohost, i_req_wdata, i_req_wstrb);
  assign w_merge_fromhost = f_merge(r_fromhost, i_req_wdata, i_req_wstrb);

  assign w_load_data = w_hit_tohost   ? r_tohost   :
                       w_hit_fromhost ? r_fromhost : 64'h0;

`ifdef TOHOST_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] r_cnt;

  // Count PENDING cycles; held at zero while idle so every PENDING entry starts fresh.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if (!w_timeout_fire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // An ack on the expiry edge takes priority over the timeout.
  assign w_timeout_fire = (r_state == ST_PENDING) && !i_tohost_ack &&
                          (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout_fire   = 1'b0;
`endif

  logic w_unused_addr;
  assign w_unused_addr = ^i_req_addr[2:0];

  // Mailbox FSM and tohost register next-state.
  always_comb begin
    w_state_next       = r_state;
    w_tohost_next      = r_tohost;
    w_timeout_err_next = r_timeout_err;
    case (r_state)
      ST_IDLE: begin
        if (w_store && w_hit_tohost) begin
          w_tohost_next = w_merge_tohost;
          // Upper-half-only stores stage data without signalling the bench.
          if (i_req_wstrb[0] && (w_merge_tohost != 64'h0)) w_state_next = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (i_tohost_ack) begin
          w_tohost_next = 64'h0;
          w_state_next  = ST_IDLE;
        end else if (w_timeout_fire) begin
          w_tohost_next      = 64'h0;
          w_state_next       = ST_IDLE;
          w_timeout_err_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Fromhost register next-state: bench push beats a same-cycle software store.
  always_comb begin
    w_fromhost_next = r_fromhost;
    if (i_fromhost_valid) begin
      w_fromhost_next = i_fromhost_data;
    end else if (w_store && w_hit_fromhost) begin
      w_fromhost_next = w_merge_fromhost;
    end
  end

  // State and mailbox registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_tohost      <= 64'h0;
      r_fromhost    <= 64'h0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_tohost      <= w_tohost_next;
      r_fromhost    <= w_fromhost_next;
      r_timeout_err <= w_timeout_err_next;
    end
  end

  // One-cycle response; load data is the pre-update register value.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 64'h0;
    end else begin
      r_resp_valid <= w_accept;
      r_resp_rdata <= w_load ? w_load_data : 64'h0;
    end
  end

  assign o_resp_valid  = r_resp_valid;
  assign o_resp_rdata  = r_resp_rdata;
  assign o_tohost      = r_tohost;
  assign o_busy        = (r_state == ST_PENDING);
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tohost_mailbox.sv
// Self-checking bench for tohost_mailbox: directed scenarios plus randomized traffic against
// a transaction-level reference model. Timeout scenario built only with TOHOST_TIMEOUT_EN.
module tb_tohost_mailbox;

  localparam logic [31:0] TO_A   = 32'h8000_1000;
  localparam logic [31:0] FH_A   = 32'h8000_1040;
  localparam logic [31:0] UN_A   = 32'h8000_2000;
  localparam int unsigned TO_CYC = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata, tohost;
  logic        tohost_ack = 1'b0, fromhost_valid = 1'b0;
  logic [63:0] fromhost_data = '0;
  logic        busy, timeout_err;

  always #5 clk = ~clk;

  tohost_mailbox #(
    .ADDR_W        (32),
    .TOHOST_ADDR   (TO_A),
    .FROMHOST_ADDR (FH_A),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_write     (req_write),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .i_req_wstrb     (req_wstrb),
    .o_resp_valid    (resp_valid),
    .o_resp_rdata    (resp_rdata),
    .o_tohost        (tohost),
    .i_tohost_ack    (tohost_ack),
    .i_fromhost_valid(fromhost_valid),
    .i_fromhost_data (fromhost_data),
    .o_busy          (busy),
    .o_timeout_err   (timeout_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mailbox contents, whether the bench owes an ack, and how long it has waited.
  logic [63:0] m_tohost, m_fromhost;
  bit          m_pending, m_terr;
  int          m_age;
  bit          e_ready, e_resp_v, obs_ready;
  logic [63:0] e_rdata;

  function automatic bit hit(input logic [31:0] a, input logic [31:0] base);
    return (a >> 3) == (base >> 3);
  endfunction

  function automatic logic [63:0] bmerge(input logic [63:0] old_v, input logic [63:0] new_v,
                                         input logic [7:0] s);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) if (s[i]) mask = mask | (64'hFF << (8 * i));
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_reset();
    m_tohost = '0; m_fromhost = '0; m_pending = 0; m_terr = 0; m_age = 0;
  endtask

  // One clock: drive at posedge+1, sample ready at negedge, advance model, return at posedge+1.
  task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [63:0] d,
                      input logic [7:0] s, input bit ack, input bit fhv, input logic [63:0] fhd);
    bit acc;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    tohost_ack = ack; fromhost_valid = fhv; fromhost_data = fhd;
    @(negedge clk);
    obs_ready = req_ready;
    e_ready  = !(m_pending && hit(a, TO_A));
    acc      = v && e_ready;
    e_resp_v = acc;
    e_rdata  = 64'h0;
    if (acc && !w) e_rdata = hit(a, TO_A) ? m_tohost : (hit(a, FH_A) ? m_fromhost : 64'h0);
    if (m_pending) begin
      if (ack) begin
        m_tohost = '0; m_pending = 0;
      end else begin
        m_age++;
`ifdef TOHOST_TIMEOUT_EN
        if (m_age == int'(TO_CYC)) begin
          m_tohost = '0; m_pending = 0; m_terr = 1;
        end
`endif
      end
    end else if (acc && w && hit(a, TO_A)) begin
      m_tohost = bmerge(m_tohost, d, s);
      if (s[0] && m_tohost != 0) begin
        m_pending = 1; m_age = 0;
      end
    end
    if (fhv) m_fromhost = fhd;
    else if (acc && w && hit(a, FH_A)) m_fromhost = bmerge(m_fromhost, d, s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, UN_A, 64'h0, 8'h0, 0, 0, 64'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (tohost !== 64'h0) begin failures++; $display("FAIL reset_tohost got=%h exp=0", tohost); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 64'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_tohost_store();
    step(1, 1, TO_A, 64'h1, 8'hFF, 0, 0, 64'h0);
    checks++; if (tohost !== 64'h1) begin failures++; $display("FAIL store_tohost got=%h exp=1", tohost); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL store_busy got=%b exp=1", busy); end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL store_resp_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_rdata !== 64'h0) begin failures++; $display("FAIL store_rdata got=%h exp=0", resp_rdata); end
    idle();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL store_resp_pulse got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL store_busy_hold got=%b exp=1", busy); end
    step(0, 0, UN_A, 64'h0, 8'h0, 1, 0, 64'h0);
    checks++; if (tohost !== 64'h0) begin failures++; $display("FAIL ack_tohost got=%h exp=0", tohost); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ack_busy got=%b exp=0", busy); end
  endtask

  task automatic test_split_store();
    step(1, 1, TO_A | 32'h4, 64'hDEAD_0000_0000_0000, 8'hF0, 0, 0, 64'h0);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL split_hi_busy got=%b exp=0", busy); end
    checks++; if (tohost !== 64'hDEAD_0000_0000_0000) begin failures++; $display("FAIL split_hi_tohost got=%h exp=dead000000000000", tohost); end
    step(1, 1, TO_A, 64'h3, 8'h0F, 0, 0, 64'h0);
    checks++; if (tohost !== 64'hDEAD_0000_0000_0003) begin failures++; $display("FAIL split_lo_tohost got=%h exp=dead000000000003", tohost); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL split_lo_busy got=%b exp=1", busy); end
  endtask

  // Enters PENDING from test_split_store.
  task automatic test_backpressure();
    step(1, 0, FH_A, 64'h0, 8'h0, 0, 0, 64'h0);
    checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL bp_other_ready got=%b exp=1", obs_ready); end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_other_resp got=%b exp=1", resp_valid); end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, TO_A, 64'h77, 8'hFF, 0, 0, 64'h0);
      checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, obs_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_resp cyc=%0d got=%b exp=0", i, resp_valid); end
    end
    step(1, 1, TO_A, 64'h77, 8'hFF, 1, 0, 64'h0);
    checks++; if (tohost !== 64'h0) begin failures++; $display("FAIL bp_ack_tohost got=%h exp=0", tohost); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL bp_ack_ready got=%b exp=1", req_ready); end
    step(1, 1, TO_A, 64'h77, 8'hFF, 0, 0, 64'h0);
    checks++; if (tohost !== 64'h77) begin failures++; $display("FAIL bp_held_tohost got=%h exp=77", tohost); end
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_held_resp got=%b exp=1", resp_valid); end
    step(0, 0, UN_A, 64'h0, 8'h0, 1, 0, 64'h0);
  endtask

  task automatic test_fromhost_collision();
    step(1, 1, FH_A, 64'h0, 8'hFF, 0, 1, 64'h55);
    step(1, 0, FH_A, 64'h0, 8'h0, 0, 0, 64'h0);
    checks++; if (resp_rdata !== 64'h55) begin failures++; $display("FAIL fh_collision got=%h exp=55", resp_rdata); end
  endtask

  task automatic test_unmapped();
    step(1, 0, UN_A, 64'h0, 8'h0, 0, 0, 64'h0);
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL unm_resp got=%b exp=1", resp_valid); end
    checks++; if (resp_rdata !== 64'h0) begin failures++; $display("FAIL unm_rdata got=%h exp=0", resp_rdata); end
    step(1, 1, UN_A, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 64'h0);
    step(1, 0, TO_A, 64'h0, 8'h0, 0, 0, 64'h0);
    checks++; if (resp_rdata !== 64'h0) begin failures++; $display("FAIL unm_tohost got=%h exp=0", resp_rdata); end
    step(1, 0, FH_A, 64'h0, 8'h0, 0, 0, 64'h0);
    checks++; if (resp_rdata !== 64'h55) begin failures++; $display("FAIL unm_fromhost got=%h exp=55", resp_rdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL unm_busy got=%b exp=0", busy); end
  endtask

`ifdef TOHOST_TIMEOUT_EN
  task automatic test_timeout();
    step(1, 1, TO_A, 64'h1, 8'hFF, 0, 0, 64'h0);
    for (int i = 0; i < int'(TO_CYC) - 1; i++) begin
      idle();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_wait_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    idle();
    checks++; if (tohost !== 64'h0) begin failures++; $display("FAIL to_tohost got=%h exp=0", tohost); end
    checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", timeout_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", busy); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  s;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(3))
        0: a = TO_A | 32'($urandom_range(7));
        1: a = FH_A | 32'($urandom_range(7));
        2: a = UN_A;
        default: a = $urandom;
      endcase
      d = ($urandom_range(3) == 0) ? 64'h0 : {$urandom, $urandom};
      s = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom_range(255));
      step(bit'($urandom_range(3) != 0), bit'($urandom_range(1)), a, d, s,
           bit'($urandom_range(3) == 0), bit'($urandom_range(7) == 0), {$urandom, $urandom});
      checks++; if (obs_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, obs_ready, e_ready); end
      checks++; if (resp_valid !== e_resp_v) begin failures++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", c, resp_valid, e_resp_v); end
      checks++; if (resp_rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, resp_rdata, e_rdata); end
      checks++; if (tohost !== m_tohost) begin failures++; $display("FAIL rnd_tohost cyc=%0d got=%h exp=%h", c, tohost, m_tohost); end
      checks++; if (busy !== m_pending) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, m_pending); end
      checks++; if (timeout_err !== m_terr) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, timeout_err, m_terr); end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, UN_A, 64'h0, 8'h0, 1, 0, 64'h0);
    step(1, 1, TO_A, 64'h9, 8'hFF, 0, 0, 64'h0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_pre_busy got=%b exp=1", busy); end
    req_valid = 1'b1; req_write = 1'b0; req_addr = FH_A;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (tohost !== 64'h0) begin failures++; $display("FAIL ar_tohost got=%h exp=0", tohost); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%b exp=0", busy); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL ar_resp got=%b exp=0", resp_valid); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL ar_err got=%b exp=0", timeout_err); end
    @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL ar_inflight_resp got=%b exp=0", resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, TO_A, 64'h0, 8'h0, 0, 0, 64'h0);
    checks++; if (resp_rdata !== 64'h0) begin failures++; $display("FAIL ar_load_tohost got=%h exp=0", resp_rdata); end
    checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", obs_ready); end
  endtask

  initial begin
    test_reset();
    test_tohost_store();
    test_split_store();
    test_backpressure();
    test_fromhost_collision();
    test_unmapped();
`ifdef TOHOST_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
